// File: rtl/bka_multiword_sequencer.sv
// Wide add/sub over LIMBS x N bits, one limb per cycle through one Brent-Kung adder; done LIMBS+1 cycles after accept.
// No backpressure: start is honoured only in IDLE, and a start in RUN or DONE is dropped rather than queued.

module generic_BKA #(
  parameter int n = 64
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);
  localparam int L = $clog2(n);

  logic [n-1:0] hp;
  logic [n-1:0] g;
  logic [n-1:0] p;

  always_comb begin
    hp   = a ^ b;
    p    = hp;
    g    = a & b;
    // cin is folded into bit 0, so g[i] becomes the carry out of bit i
    g[0] = g[0] | (hp[0] & cin);
    for (int l = 0; l < L; l++) begin
      for (int i = (2 << l) - 1; i < n; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    for (int l = L - 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < n; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    sum  = hp ^ {g[n-2:0], cin};
    cout = g[n-1];
  end
endmodule

module bka_multiword_sequencer #(
  parameter int N     = 64,
  parameter int LIMBS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic                 cin_in,
  input  logic [N*LIMBS-1:0]   a,
  input  logic [N*LIMBS-1:0]   b,
  output logic                 busy,
  output logic                 done,
  output logic [N*LIMBS-1:0]   result,
  output logic                 cout,
  output logic                 overflow
);
  localparam int CW = $clog2(LIMBS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [LIMBS-1:0][N-1:0]  a_reg;
  logic [LIMBS-1:0][N-1:0]  b_reg;
  logic [LIMBS-1:0][N-1:0]  res_reg;
  logic [CW-1:0]            cnt;
  logic                     carry_reg;
  logic                     last;
  logic [N-1:0]             add_sum;
  logic                     add_cout;

  generic_BKA #(.n(N)) u_bka (
    .a    (a_reg[cnt]),
    .b    (b_reg[cnt]),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last   = (cnt == CW'(LIMBS - 1));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = res_reg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            // subtraction is a + ~b + 1, so only B and the initial carry change
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? 1'b1 : cin_in;
            cnt       <= '0;
            res_reg   <= '0;
          end
        end
        RUN: begin
          res_reg[cnt] <= add_sum;
          carry_reg    <= add_cout;
          if (last) begin
            cout     <= add_cout;
            overflow <= (a_reg[LIMBS-1][N-1] == b_reg[LIMBS-1][N-1]) &&
                        (add_sum[N-1] != a_reg[LIMBS-1][N-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bka_multiword_sequencer.sv
// Directed and random checks of bka_multiword_sequencer with N=8, LIMBS=4.
module tb_bka_multiword_sequencer;
  localparam int N = 8;
  localparam int LIMBS = 4;
  localparam int W = N * LIMBS;
  localparam int LAT = LIMBS + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  bka_multiword_sequencer #(.N(N), .LIMBS(LIMBS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .cin_in   (cin_in),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Drives one operation and waits (bounded) for done; lat is cycles from accept edge to done.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic icin, output logic [W-1:0] r, output logic co,
                       output logic ov, output int lat);
    @(negedge clk);
    a = ia; b = ib; op_sub = isub; cin_in = icin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = result; co = cout; ov = overflow;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b, required all zero",
               busy, done, result, cout, overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain;
    logic [W-1:0] r; logic co, ov; int lat;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    checks++;
    if (r !== 32'h00000000 || co !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("FAIL carry_chain: got %h/%b/%b, required 00000000/1/0", r, co, ov);
    end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL carry_latency: got %0d, required %0d", lat, LAT);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b one cycle after done, required 0/0", done, busy);
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] r; logic co, ov; int lat;
    do_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, r, co, ov, lat);
    checks++;
    if (r !== 32'hFFFFFFFE || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: got %h/%b/%b, required FFFFFFFE/0/0", r, co, ov);
    end
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, r, co, ov, lat);
    checks++;
    if (r !== 32'h7FFFFFFF || co !== 1'b1 || ov !== 1'b1) begin
      errors++;
      $display("FAIL sub_overflow: got %h/%b/%b, required 7FFFFFFF/1/1", r, co, ov);
    end
  endtask

  task automatic test_add_overflow;
    logic [W-1:0] r; logic co, ov; int lat;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, r, co, ov, lat);
    checks++;
    if (r !== 32'h80000000 || co !== 1'b0 || ov !== 1'b1) begin
      errors++;
      $display("FAIL add_overflow: got %h/%b/%b, required 80000000/0/1", r, co, ov);
    end
    do_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, r, co, ov, lat);
    checks++;
    if (r !== 32'h2345678A || co !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL add_cin: got %h/%b/%b, required 2345678A/0/0", r, co, ov);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ndone;
    @(negedge clk);
    a = 32'h01020304; b = 32'h10203040; op_sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    cyc = 0; ndone = 0;
    while (ndone == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) ndone++;
      else begin
        a = $urandom; b = $urandom; op_sub = 1'($urandom); cin_in = 1'($urandom);
      end
    end
    checks++;
    if (cyc !== LAT || result !== 32'h11223344) begin
      errors++;
      $display("FAIL start_ignored: done at %0d result %h, required %0d / 11223344", cyc, result, LAT);
    end
    // start still held: ignored in DONE, accepted at the edge ending the IDLE cycle
    a = 32'h000000FF; b = 32'h00000001; op_sub = 1'b0; cin_in = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b after done, required 0/0", done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== LAT || result !== 32'h00000100) begin
      errors++;
      $display("FAIL second_op: done at %0d result %h, required %0d / 00000100", cyc, result, LAT);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] r; logic co, ov; int lat, seen;
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; op_sub = 1'b0; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (result !== 32'h00000033 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_limb: result %h busy %b, required 00000033/1", result, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h cout=%b, required 0/0/0/0",
               busy, done, result, cout);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL aborted_done: %0d done pulses, required 0", seen);
    end
    do_op(32'h00000003, 32'h00000004, 1'b0, 1'b0, r, co, ov, lat);
    checks++;
    if (r !== 32'h00000007 || co !== 1'b0 || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset: got %h/%b lat %0d, required 00000007/0 lat %0d", r, co, lat, LAT);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb, r, eb; logic rs, rc, co, ov, eov; logic [W:0] ref_sum; int lat;
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      if (k < 8) begin
        ra = (k[0]) ? 32'hFFFFFFFF : 32'h80000000;
        rb = (k[1]) ? 32'h7FFFFFFF : 32'h00000000;
      end
      eb = rs ? ~rb : rb;
      ref_sum = {1'b0, ra} + {1'b0, eb} + ((rs ? 1'b1 : rc) ? 33'd1 : 33'd0);
      eov = rs ? ((ra[W-1] != rb[W-1]) && (ref_sum[W-1] != ra[W-1]))
               : ((ra[W-1] == rb[W-1]) && (ref_sum[W-1] != ra[W-1]));
      do_op(ra, rb, rs, rc, r, co, ov, lat);
      checks++;
      if (r !== ref_sum[W-1:0] || co !== ref_sum[W] || ov !== eov) begin
        errors++;
        $display("FAIL random[%0d]: %h %s %h cin %b got %h/%b/%b, required %h/%b/%b",
                 k, ra, rs ? "-" : "+", rb, rc, r, co, ov, ref_sum[W-1:0], ref_sum[W], eov);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL random_latency[%0d]: got %0d, required %0d", k, lat, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_sub();
    test_add_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
